// File: rtl/instr_sequencer_if.sv
// Memory-side bus of the instruction sequencer: the instruction-fetch port
// and the data-memory access port, grouped so they travel as one bundle.
interface instr_sequencer_if #(
  parameter int PC_WIDTH = 8
);
  logic [PC_WIDTH-1:0] imem_addr;
  logic                imem_req;
  logic                imem_ack;
  logic [15:0]         imem_data;
  logic                dmem_req;
  logic                dmem_we;
  logic                dmem_ack;

  // Sequencer side: issues fetch and data requests, receives acks and data
  modport master (
    output imem_addr,
    output imem_req,
    input  imem_ack,
    input  imem_data,
    output dmem_req,
    output dmem_we,
    input  dmem_ack
  );

  // Memory side: answers fetch and data requests
  modport slave (
    input  imem_addr,
    input  imem_req,
    output imem_ack,
    output imem_data,
    input  dmem_req,
    input  dmem_we,
    output dmem_ack
  );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer. Steps each instruction through
// FETCH, DECODE, EXEC, optional MEM and WB, owns the program counter,
// resolves jumps from the decoder's jump control and the register-A flags,
// and counts retired instructions. All request strobes are decoded from
// the registered state so they only move on clock edges.
module instr_sequencer #(
  parameter int                  PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  instr_sequencer_if.master   bus,
  output logic [15:0]         instr,
  input  logic [1:0]          JCTL,
  input  logic [PC_WIDTH-1:0] jump_addr,
  input  logic                a_zero,
  input  logic                a_neg,
  input  logic                data_read,
  input  logic                data_write,
  input  logic                reg_write,
  output logic                reg_we,
  output logic [PC_WIDTH-1:0] pc,
  output logic [2:0]          state,
  output logic [15:0]         retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  state_t              r_state;
  logic [PC_WIDTH-1:0] r_pc;
  logic [15:0]         r_instr;
  logic                r_taken;
  logic [15:0]         r_retired;

  logic                w_taken;
  logic                w_mem_op;
  logic [PC_WIDTH-1:0] w_pc_inc;

  assign w_taken  = ((JCTL == 2'd1) && a_zero) ||
                    ((JCTL == 2'd2) && a_neg)  ||
                     (JCTL == 2'd3);
  assign w_mem_op = data_read || data_write;
  assign w_pc_inc = r_pc + {{(PC_WIDTH-1){1'b0}}, 1'b1};

  // Strobes decoded from the registered state; a read wins over a write
  assign bus.imem_addr = r_pc;
  assign bus.imem_req  = (r_state == S_FETCH);
  assign bus.dmem_req  = (r_state == S_MEM);
  assign bus.dmem_we   = (r_state == S_MEM) && data_write && !data_read;
  assign reg_we        = (r_state == S_WB) && reg_write;

  assign instr   = r_instr;
  assign pc      = r_pc;
  assign state   = r_state;
  assign retired = r_retired;

  // Sequencer FSM with its instruction register, jump flag, pc and retire count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_pc      <= RESET_PC;
      r_instr   <= 16'h0000;
      r_taken   <= 1'b0;
      r_retired <= 16'h0000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (run) r_state <= S_FETCH;
        end
        S_FETCH: begin
          if (bus.imem_ack) begin
            r_instr <= bus.imem_data;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_taken <= w_taken;
          r_state <= w_mem_op ? S_MEM : S_WB;
        end
        S_MEM: begin
          if (bus.dmem_ack) r_state <= S_WB;
        end
        S_WB: begin
          r_pc      <= r_taken ? jump_addr : w_pc_inc;
          r_retired <= r_retired + 16'd1;
          r_state   <= run ? S_FETCH : S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer. The bench plays both the memories
// and the control_logic decoder, driving decoder outputs by hand for each
// instruction it feeds in. Inputs change and outputs are sampled on the
// falling clock edge.
module tb_instr_sequencer;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic [15:0] instr;
  logic [1:0]  JCTL;
  logic [7:0]  jump_addr;
  logic        a_zero;
  logic        a_neg;
  logic        data_read;
  logic        data_write;
  logic        reg_write;
  logic        reg_we;
  logic [7:0]  pc;
  logic [2:0]  state;
  logic [15:0] retired;

  int testsRun;
  int testsFailed;
  int expRetired;

  instr_sequencer_if #(.PC_WIDTH(8)) bus ();

  instr_sequencer #(.PC_WIDTH(8), .RESET_PC(8'h00)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .bus        (bus),
    .instr      (instr),
    .JCTL       (JCTL),
    .jump_addr  (jump_addr),
    .a_zero     (a_zero),
    .a_neg      (a_neg),
    .data_read  (data_read),
    .data_write (data_write),
    .reg_write  (reg_write),
    .reg_we     (reg_we),
    .pc         (pc),
    .state      (state),
    .retired    (retired)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_decode(input logic [1:0] jctl, input logic [7:0] jaddr,
                            input logic rd, input logic wr, input logic rw);
    JCTL       = jctl;
    jump_addr  = jaddr;
    data_read  = rd;
    data_write = wr;
    reg_write  = rw;
  endtask

  // From a FETCH cycle: present an instruction with a zero-wait ack, ends in DECODE
  task automatic do_fetch(input logic [15:0] data);
    bus.imem_data = data;
    bus.imem_ack  = 1'b1;
    cyc();
    bus.imem_ack  = 1'b0;
  endtask

  // From a FETCH cycle: run one non-memory instruction through to the next FETCH
  task automatic run_simple(input logic [15:0] data, input logic [1:0] jctl,
                            input logic [7:0] jaddr, input logic az, input logic an);
    set_decode(jctl, jaddr, 1'b0, 1'b0, 1'b0);
    a_zero = az;
    a_neg  = an;
    do_fetch(data);
    cyc();
    cyc();
    cyc();
    a_zero = 1'b0;
    a_neg  = 1'b0;
    expRetired++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    run   = 1'b0;
    cyc();
    cyc();
    testsRun++;
    if (state !== 3'd0) begin testsFailed++; $display("[TB] FAIL reset_state: got %0d want 0", state); end
    testsRun++;
    if (pc !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset_pc: got %h want 00", pc); end
    testsRun++;
    if (instr !== 16'h0000 || retired !== 16'h0000) begin
      testsFailed++; $display("[TB] FAIL reset_regs: instr %h retired %h want 0000 0000", instr, retired);
    end
    testsRun++;
    if ({bus.imem_req, bus.dmem_req, bus.dmem_we, reg_we} !== 4'b0000) begin
      testsFailed++; $display("[TB] FAIL reset_strobes: got %b want 0000",
                              {bus.imem_req, bus.dmem_req, bus.dmem_we, reg_we});
    end
  endtask

  task automatic test_alu();
    set_decode(2'd0, 8'h00, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
    run   = 1'b1;
    cyc();
    testsRun++;
    if (state !== 3'd1 || bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h00) begin
      testsFailed++; $display("[TB] FAIL alu_fetch: state %0d req %b addr %h want 1 1 00",
                              state, bus.imem_req, bus.imem_addr);
    end
    do_fetch(16'h4975);
    testsRun++;
    if (state !== 3'd2 || instr !== 16'h4975 || bus.imem_req !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL alu_decode: state %0d instr %h req %b want 2 4975 0",
                              state, instr, bus.imem_req);
    end
    cyc();
    testsRun++;
    if (state !== 3'd3 || reg_we !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL alu_exec: state %0d reg_we %b want 3 0", state, reg_we);
    end
    cyc();
    testsRun++;
    if (state !== 3'd5 || reg_we !== 1'b1 || pc !== 8'h00) begin
      testsFailed++; $display("[TB] FAIL alu_wb: state %0d reg_we %b pc %h want 5 1 00", state, reg_we, pc);
    end
    cyc();
    expRetired++;
    testsRun++;
    if (state !== 3'd1 || reg_we !== 1'b0 || pc !== 8'h01 || retired !== 16'd1) begin
      testsFailed++; $display("[TB] FAIL alu_next: state %0d reg_we %b pc %h retired %0d want 1 0 01 1",
                              state, reg_we, pc, retired);
    end
  endtask

  task automatic test_load();
    int reqCycles;
    reqCycles = 0;
    set_decode(2'd0, 8'h85, 1'b1, 1'b0, 1'b1);
    do_fetch(16'h1585);
    cyc();
    cyc();
    for (int i = 0; i < 4; i++) begin
      if (state == 3'd4 && bus.dmem_req === 1'b1 && bus.dmem_we === 1'b0) reqCycles++;
      if (i == 3) bus.dmem_ack = 1'b1;
      cyc();
    end
    bus.dmem_ack = 1'b0;
    testsRun++;
    if (reqCycles !== 4) begin
      testsFailed++; $display("[TB] FAIL load_mem_cycles: got %0d want 4", reqCycles);
    end
    testsRun++;
    if (state !== 3'd5 || reg_we !== 1'b1 || bus.dmem_req !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL load_wb: state %0d reg_we %b dmem_req %b want 5 1 0",
                              state, reg_we, bus.dmem_req);
    end
    cyc();
    expRetired++;
    testsRun++;
    if (pc !== 8'h02 || retired !== expRetired[15:0]) begin
      testsFailed++; $display("[TB] FAIL load_pc: pc %h retired %0d want 02 %0d", pc, retired, expRetired);
    end
  endtask

  task automatic test_store();
    set_decode(2'd0, 8'h43, 1'b0, 1'b1, 1'b0);
    do_fetch(16'h3543);
    cyc();
    cyc();
    testsRun++;
    if (state !== 3'd4 || bus.dmem_req !== 1'b1 || bus.dmem_we !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL store_mem: state %0d req %b we %b want 4 1 1",
                              state, bus.dmem_req, bus.dmem_we);
    end
    bus.dmem_ack = 1'b1;
    cyc();
    bus.dmem_ack = 1'b0;
    testsRun++;
    if (state !== 3'd5 || reg_we !== 1'b0 || bus.dmem_we !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL store_wb: state %0d reg_we %b we %b want 5 0 0",
                              state, reg_we, bus.dmem_we);
    end
    cyc();
    expRetired++;
    testsRun++;
    if (pc !== 8'h03) begin testsFailed++; $display("[TB] FAIL store_pc: got %h want 03", pc); end
  endtask

  task automatic test_jumps();
    run_simple(16'hF010, 2'd3, 8'h10, 1'b0, 1'b0);
    testsRun++;
    if (pc !== 8'h10) begin testsFailed++; $display("[TB] FAIL j_to_10: got %h want 10", pc); end
    run_simple(16'hD257, 2'd1, 8'h57, 1'b1, 1'b0);
    testsRun++;
    if (pc !== 8'h57) begin testsFailed++; $display("[TB] FAIL jz_taken: got %h want 57", pc); end
    run_simple(16'hF010, 2'd3, 8'h10, 1'b0, 1'b0);
    run_simple(16'hD257, 2'd1, 8'h57, 1'b0, 1'b1);
    testsRun++;
    if (pc !== 8'h11) begin testsFailed++; $display("[TB] FAIL jz_not_taken: got %h want 11", pc); end
    run_simple(16'hE365, 2'd2, 8'h65, 1'b0, 1'b1);
    testsRun++;
    if (pc !== 8'h65) begin testsFailed++; $display("[TB] FAIL jlt_taken: got %h want 65", pc); end
    run_simple(16'hE365, 2'd2, 8'h30, 1'b1, 1'b0);
    testsRun++;
    if (pc !== 8'h66) begin testsFailed++; $display("[TB] FAIL jlt_not_taken: got %h want 66", pc); end
    run_simple(16'hF075, 2'd3, 8'h75, 1'b0, 1'b0);
    testsRun++;
    if (pc !== 8'h75) begin testsFailed++; $display("[TB] FAIL j_uncond: got %h want 75", pc); end
    run_simple(16'hF0FF, 2'd3, 8'hFF, 1'b0, 1'b0);
    run_simple(16'h0000, 2'd0, 8'h00, 1'b1, 1'b1);
    testsRun++;
    if (pc !== 8'h00) begin testsFailed++; $display("[TB] FAIL pc_wrap: got %h want 00", pc); end
    testsRun++;
    if (retired !== expRetired[15:0]) begin
      testsFailed++; $display("[TB] FAIL retired_count: got %0d want %0d", retired, expRetired);
    end
  endtask

  task automatic test_back_to_back();
    // Two fetch wait cycles stretch FETCH, then a stray dmem ack outside MEM
    set_decode(2'd0, 8'h00, 1'b0, 1'b0, 1'b1);
    bus.imem_data = 16'h4975;
    cyc();
    cyc();
    testsRun++;
    if (state !== 3'd1 || bus.imem_req !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL fetch_wait: state %0d req %b want 1 1", state, bus.imem_req);
    end
    bus.dmem_ack = 1'b1;
    do_fetch(16'h4975);
    cyc();
    cyc();
    bus.dmem_ack = 1'b0;
    testsRun++;
    if (state !== 3'd5 || reg_we !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL stray_dmem_ack: state %0d reg_we %b want 5 1", state, reg_we);
    end
    cyc();
    expRetired++;
    testsRun++;
    if (pc !== 8'h01 || state !== 3'd1) begin
      testsFailed++; $display("[TB] FAIL b2b_next: pc %h state %0d want 01 1", pc, state);
    end
  endtask

  task automatic test_reset_in_mem();
    set_decode(2'd0, 8'h85, 1'b1, 1'b0, 1'b1);
    do_fetch(16'h1585);
    cyc();
    cyc();
    testsRun++;
    if (state !== 3'd4 || bus.dmem_req !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL rst_pre_mem: state %0d dmem_req %b want 4 1", state, bus.dmem_req);
    end
    rst_n = 1'b0;
    bus.dmem_ack = 1'b1;
    cyc();
    bus.dmem_ack = 1'b0;
    expRetired = 0;
    testsRun++;
    if (state !== 3'd0 || bus.dmem_req !== 1'b0 || pc !== 8'h00 || retired !== 16'd0 || instr !== 16'h0000) begin
      testsFailed++; $display("[TB] FAIL rst_in_mem: state %0d req %b pc %h retired %0d instr %h want 0 0 00 0 0000",
                              state, bus.dmem_req, pc, retired, instr);
    end
  endtask

  task automatic test_run_low();
    set_decode(2'd0, 8'h00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    run   = 1'b1;
    cyc();
    do_fetch(16'h0000);
    cyc();
    run = 1'b0;
    cyc();
    testsRun++;
    if (state !== 3'd5 || reg_we !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL runlow_wb: state %0d reg_we %b want 5 0", state, reg_we);
    end
    bus.imem_ack = 1'b1;
    cyc();
    expRetired++;
    testsRun++;
    if (state !== 3'd0 || pc !== 8'h01 || retired !== 16'd1 || bus.imem_req !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL runlow_idle: state %0d pc %h retired %0d req %b want 0 01 1 0",
                              state, pc, retired, bus.imem_req);
    end
    cyc();
    cyc();
    bus.imem_ack = 1'b0;
    testsRun++;
    if (state !== 3'd0 || bus.imem_req !== 1'b0 || instr !== 16'h0000) begin
      testsFailed++; $display("[TB] FAIL runlow_hold: state %0d req %b instr %h want 0 0 0000",
                              state, bus.imem_req, instr);
    end
  endtask

  initial begin
    testsRun      = 0;
    testsFailed   = 0;
    expRetired    = 0;
    rst_n         = 1'b0;
    run           = 1'b0;
    a_zero        = 1'b0;
    a_neg         = 1'b0;
    bus.imem_ack  = 1'b0;
    bus.imem_data = 16'h0000;
    bus.dmem_ack  = 1'b0;
    set_decode(2'd0, 8'h00, 1'b0, 1'b0, 1'b0);

    test_reset();
    test_alu();
    test_load();
    test_store();
    test_jumps();
    test_back_to_back();
    test_reset_in_mem();
    test_run_low();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
